exec_seq: RTL and testbench

//   Clocked, parametrised successor to the single-cycle RV32I execute unit.
//   - Accepts one decoded instruction at a time over a valid/ready handshake.
//   - Owns the 32x32 register file (x0 hardwired to zero), the byte-wide data memory and the PC.
//   - Executes ALU ops and branches in one cycle and loads/stores over a configurable memory latency.
//   - Raises a sticky trap on misaligned accesses or branch targets.

---
 rtl/exec_if.sv | 26 ++
 rtl/exec_seq.sv | 195 +++++++++++++++++++
 tb/tb_exec_seq.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_if.sv
// exec_if: instruction handshake, architectural status and debug read port of exec_seq
interface exec_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        funct7_5;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        retire;
    logic        trap;
    logic [3:0]  trap_cause;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    modport master (
        output in_valid, opcode, rd, funct3, rs1, rs2, funct7_5, imm, dbg_raddr,
        input  in_ready, pc, retire, trap, trap_cause, dbg_rdata
    );
    modport slave (
        input  in_valid, opcode, rd, funct3, rs1, rs2, funct7_5, imm, dbg_raddr,
        output in_ready, pc, retire, trap, trap_cause, dbg_rdata
    );
endinterface

// File: rtl/exec_seq.sv
// exec_seq: clocked RV32I execute stage owning the register file, byte data memory and PC
module exec_seq #(
    parameter int          DMEM_AW  = 10,
    parameter int          MEM_LAT  = 1,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic   clk,
    input logic   rst,
    exec_if.slave bus
);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;

    typedef enum logic [1:0] {IDLE, MEM, TRAP} state_t;

    state_t             state_q, state_d;
    logic [31:0]        regs [32];
    logic [7:0]         dmem [2**DMEM_AW];
    logic [31:0]        pc_q;
    logic               retire_q, trap_q;
    logic [3:0]         cause_q;
    logic [CW-1:0]      cnt_q;
    logic [DMEM_AW-1:0] maddr_q, a1, a2, a3, addr;
    logic [31:0]        sdata_q;
    logic [4:0]         mrd_q;
    logic [2:0]         mf3_q;
    logic               mstore_q;
    logic [31:0]        rs1v, rs2v, opb, alu, sra, ea, br_tgt, pc_next, wdata, ld_raw, ldata;
    logic [4:0]         shamt;
    logic               accept, is_mem, taken, wr_en, fault, misaligned, mem_done;
    logic [3:0]         fault_cause;

    assign bus.in_ready   = state_q == IDLE;
    assign bus.pc         = pc_q;
    assign bus.retire     = retire_q;
    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;
    assign bus.dbg_rdata  = regs[bus.dbg_raddr];

    assign accept = bus.in_valid && state_q == IDLE;
    assign is_mem = bus.opcode == OP_LOAD || bus.opcode == OP_STORE;
    assign rs1v   = regs[bus.rs1];
    assign rs2v   = regs[bus.rs2];
    assign opb    = bus.opcode == OP_OP ? rs2v : bus.imm;
    assign shamt  = opb[4:0];
    assign sra    = $signed(rs1v) >>> shamt;
    assign ea     = rs1v + bus.imm;
    assign br_tgt = pc_q + bus.imm;
    assign addr   = ea[DMEM_AW-1:0];
    // funct3[1] selects word, funct3[0] halfword; anything else is a byte access
    assign misaligned = bus.funct3[1] ? |addr[1:0] : bus.funct3[0] & addr[0];

    always_comb begin
        case (bus.funct3)
            3'b000:  alu = (bus.opcode == OP_OP && bus.funct7_5) ? rs1v - opb : rs1v + opb;
            3'b001:  alu = rs1v << shamt;
            3'b010:  alu = {31'b0, $signed(rs1v) < $signed(opb)};
            3'b011:  alu = {31'b0, rs1v < opb};
            3'b100:  alu = rs1v ^ opb;
            3'b101:  alu = bus.funct7_5 ? sra : rs1v >> shamt;
            3'b110:  alu = rs1v | opb;
            default: alu = rs1v & opb;
        endcase
    end

    always_comb begin
        case (bus.funct3)
            3'b000:  taken = rs1v == rs2v;
            3'b001:  taken = rs1v != rs2v;
            3'b100:  taken = $signed(rs1v) < $signed(rs2v);
            3'b101:  taken = $signed(rs1v) >= $signed(rs2v);
            3'b110:  taken = rs1v < rs2v;
            3'b111:  taken = rs1v >= rs2v;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        wr_en       = 1'b0;
        wdata       = alu;
        pc_next     = pc_q + 32'd4;
        fault       = 1'b0;
        fault_cause = 4'd0;
        case (bus.opcode)
            OP_LUI: begin
                wr_en = 1'b1;
                wdata = bus.imm;
            end
            OP_AUIPC: begin
                wr_en = 1'b1;
                wdata = br_tgt;
            end
            OP_IMM, OP_OP: wr_en = 1'b1;
            OP_JAL, OP_JALR: begin
                wr_en   = 1'b1;
                wdata   = pc_q + 32'd4;
                pc_next = bus.opcode == OP_JAL ? br_tgt : {ea[31:1], 1'b0};
                fault   = |pc_next[1:0];
            end
            OP_BR: begin
                pc_next = taken ? br_tgt : pc_q + 32'd4;
                fault   = taken & |br_tgt[1:0];
            end
            OP_LOAD: begin
                fault       = misaligned;
                fault_cause = 4'd4;
            end
            OP_STORE: begin
                fault       = misaligned;
                fault_cause = 4'd6;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !accept ? IDLE : fault ? TRAP : is_mem ? MEM : IDLE;
            MEM:     state_d = mem_done ? IDLE : MEM;
            default: state_d = TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // the access completes on the edge where the counter would reach zero
    assign mem_done = state_q == MEM && cnt_q == CW'(1);
    assign a1       = maddr_q + DMEM_AW'(1);
    assign a2       = maddr_q + DMEM_AW'(2);
    assign a3       = maddr_q + DMEM_AW'(3);
    assign ld_raw   = {dmem[a3], dmem[a2], dmem[a1], dmem[maddr_q]};
    assign ldata    = mf3_q[1] ? ld_raw :
                      mf3_q[0] ? {{16{~mf3_q[2] & ld_raw[15]}}, ld_raw[15:0]} :
                                 {{24{~mf3_q[2] & ld_raw[7]}}, ld_raw[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            retire_q <= 1'b0;
            trap_q   <= 1'b0;
            cause_q  <= 4'd0;
            cnt_q    <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            retire_q <= 1'b0;
            if (accept && fault) begin
                trap_q  <= 1'b1;
                cause_q <= fault_cause;
            end else if (accept && is_mem) begin
                maddr_q  <= addr;
                sdata_q  <= rs2v;
                mrd_q    <= bus.rd;
                mf3_q    <= bus.funct3;
                mstore_q <= bus.opcode == OP_STORE;
                cnt_q    <= CW'(MEM_LAT);
            end else if (accept) begin
                pc_q     <= pc_next;
                retire_q <= 1'b1;
                if (wr_en && bus.rd != 5'd0) regs[bus.rd] <= wdata;
            end
            if (state_q == MEM) begin
                cnt_q <= cnt_q - 1'b1;
                if (mem_done) begin
                    pc_q     <= pc_q + 32'd4;
                    retire_q <= 1'b1;
                    if (!mstore_q && mrd_q != 5'd0) regs[mrd_q] <= ldata;
                end
            end
        end
    end

    // memory is never cleared; a reset arriving mid-access cancels the store
    always_ff @(posedge clk) begin
        if (!rst && mem_done && mstore_q) begin
            dmem[maddr_q] <= sdata_q[7:0];
            if (mf3_q[1] | mf3_q[0]) dmem[a1] <= sdata_q[15:8];
            if (mf3_q[1]) begin
                dmem[a2] <= sdata_q[23:16];
                dmem[a3] <= sdata_q[31:24];
            end
        end
    end
endmodule

// File: tb/tb_exec_seq.sv
// tb_exec_seq: randomized scoreboard bench for exec_seq against an instruction-level model
module tb_exec_seq;
    localparam int          MEM_LAT  = 3;
    localparam int          AW       = 10;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BR = 7'h63;
    localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, IMM = 7'h13, OP = 7'h33, CUSTOM = 7'h0B;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
    } instr_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] val;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb [$];

    logic [31:0] m_regs [32];
    logic [7:0]  m_mem [1024];
    logic [31:0] m_pc;

    int br_f3 [6] = '{0, 1, 4, 5, 6, 7};
    int ld_f3 [5] = '{0, 1, 2, 4, 5};

    exec_if bus ();
    exec_seq #(.DMEM_AW(AW), .MEM_LAT(MEM_LAT), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    function automatic instr_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                                  input logic [4:0] rs1, input logic [4:0] rs2, input logic f7,
                                  input logic [31:0] imm);
        instr_t i;
        i.op = op; i.rd = rd; i.f3 = f3; i.rs1 = rs1; i.rs2 = rs2; i.f7 = f7; i.imm = imm;
        return i;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_pc = RESET_PC;
    endtask

    // architectural effect of one instruction, straight from the ISA rules
    task automatic model_step(input instr_t i, output exp_t e, output bit t, output logic [3:0] c);
        logic [31:0] a, b, y, res, nxt, w;
        int sa, sz, ad;
        bit wr, cond;
        a = m_regs[i.rs1]; b = m_regs[i.rs2];
        nxt = m_pc + 4; res = 0; wr = 0; t = 0; c = 0;
        case (i.op)
            LUI:   begin res = i.imm; wr = 1; end
            AUIPC: begin res = m_pc + i.imm; wr = 1; end
            IMM, OP: begin
                y = (i.op == OP) ? b : i.imm;
                sa = int'(a);
                wr = 1;
                case (i.f3)
                    0: res = (i.op == OP && i.f7) ? a - y : a + y;
                    1: res = a << y[4:0];
                    2: res = (int'(a) < int'(y)) ? 1 : 0;
                    3: res = (a < y) ? 1 : 0;
                    4: res = a ^ y;
                    5: res = i.f7 ? 32'(sa >>> y[4:0]) : a >> y[4:0];
                    6: res = a | y;
                    default: res = a & y;
                endcase
            end
            JAL:  begin res = m_pc + 4; wr = 1; nxt = m_pc + i.imm; end
            JALR: begin res = m_pc + 4; wr = 1; nxt = (a + i.imm) & ~32'h1; end
            BR: begin
                case (i.f3)
                    0: cond = a == b;
                    1: cond = a != b;
                    4: cond = int'(a) < int'(b);
                    5: cond = int'(a) >= int'(b);
                    6: cond = a < b;
                    7: cond = a >= b;
                    default: cond = 0;
                endcase
                if (cond) nxt = m_pc + i.imm;
            end
            LOAD, STORE: begin
                ad = int'((a + i.imm) % 1024);
                sz = i.f3[1] ? 4 : i.f3[0] ? 2 : 1;
                t = (ad % sz) != 0;
                c = (i.op == LOAD) ? 4'd4 : 4'd6;
                if (!t && i.op == STORE)
                    for (int k = 0; k < sz; k++) m_mem[(ad + k) % 1024] = b[8*k +: 8];
                if (!t && i.op == LOAD) begin
                    w = 0;
                    for (int k = 0; k < sz; k++) w = w | (32'(m_mem[(ad + k) % 1024]) << (8 * k));
                    if (sz < 4 && !i.f3[2] && w[8*sz-1]) w = w - (32'd1 << (8 * sz));
                    res = w;
                    wr = 1;
                end
            end
            default: ;
        endcase
        if ((i.op == JAL || i.op == JALR || i.op == BR) && nxt[1:0] != 0) begin
            t = 1;
            c = 0;
        end
        if (!t) begin
            m_pc = nxt;
            if (wr && i.rd != 0) m_regs[i.rd] = res;
        end
        e.pc  = m_pc;
        e.rd  = i.rd;
        e.val = m_regs[i.rd];
        e.lat = (i.op == LOAD || i.op == STORE) ? MEM_LAT + 1 : 1;
        e.acc = 0;
    endtask

    // called just after a rising edge; returns just after a rising edge
    task automatic issue(input instr_t ins);
        exp_t e;
        bit t;
        logic [3:0] c;
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            check("ready_timeout", {31'b0, bus.in_ready}, 32'd1);
            return;
        end
        model_step(ins, e, t, c);
        e.acc = cyc;
        if (!t) sb.push_back(e);
        bus.opcode = ins.op; bus.rd = ins.rd; bus.funct3 = ins.f3; bus.rs1 = ins.rs1;
        bus.rs2 = ins.rs2; bus.funct7_5 = ins.f7; bus.imm = ins.imm;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("trap_flag", {31'b0, bus.trap}, {31'b0, t});
        if (t) begin
            check("trap_cause", {28'b0, bus.trap_cause}, {28'b0, c});
            check("trap_ready", {31'b0, bus.in_ready}, 32'd0);
            check("trap_pc", bus.pc, m_pc);
        end else if (ins.op == LOAD || ins.op == STORE) begin
            for (int k = 0; k < MEM_LAT; k++) begin
                check("mem_busy", {31'b0, bus.in_ready}, 32'd0);
                @(posedge clk); #1;
            end
        end
    endtask

    function automatic instr_t gen();
        instr_t i;
        int k, s, sz;
        k = $urandom_range(0, 19);
        i.rd = 5'($urandom); i.rs1 = 5'($urandom); i.rs2 = 5'($urandom);
        i.f3 = 3'($urandom); i.f7 = 1'($urandom);
        i.imm = sext12(12'($urandom));
        s = int'($urandom_range(0, 31)) - 16;
        if (k <= 5) i.op = IMM;
        else if (k <= 9) i.op = OP;
        else if (k == 10) begin
            i.op = ($urandom_range(0, 1) == 1) ? LUI : AUIPC;
            i.imm = $urandom & 32'hFFFFF000;
        end else if (k <= 12) begin
            i.op = BR;
            i.f3 = 3'(br_f3[$urandom_range(0, 5)]);
            i.imm = 32'(s * 4);
        end else if (k == 13) begin
            i.op = JAL;
            i.imm = 32'(s * 4);
        end else if (k == 14) begin
            i.op = JALR;
            i.rs1 = 0;
            i.imm = 32'($urandom_range(0, 1023) * 4 + $urandom_range(0, 1));
        end else if (k <= 18) begin
            i.op = (k <= 16) ? LOAD : STORE;
            i.f3 = (k <= 16) ? 3'(ld_f3[$urandom_range(0, 4)]) : 3'($urandom_range(0, 2));
            sz = i.f3[1] ? 4 : i.f3[0] ? 2 : 1;
            i.rs1 = 0;
            i.imm = 32'($urandom_range(0, 255) & ~(sz - 1));
        end else i.op = CUSTOM;
        return i;
    endfunction

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        check("reset_trap", {31'b0, bus.trap}, 32'd0);
        check("reset_pc", bus.pc, RESET_PC);
    endtask

    task automatic trap_case(input instr_t ins, input logic [3:0] want);
        logic [31:0] p;
        p = m_pc;
        issue(ins);
        check("trap_expected_cause", {28'b0, bus.trap_cause}, {28'b0, want});
        repeat (3) @(posedge clk);
        #1;
        check("trap_sticky", {31'b0, bus.trap}, 32'd1);
        check("trap_pc_frozen", bus.pc, p);
        check("trap_no_retire", {31'b0, bus.retire}, 32'd0);
        check("trap_ready_low", {31'b0, bus.in_ready}, 32'd0);
        do_reset();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.retire) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_retire: got retire=1 expected no pending instruction");
            end else begin
                e = sb.pop_front();
                bus.dbg_raddr = e.rd;
                #1;
                check("retire_pc", bus.pc, e.pc);
                check("rd_value", bus.dbg_rdata, e.val);
                check("retire_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.opcode = 0; bus.rd = 0; bus.funct3 = 0;
        bus.rs1 = 0; bus.rs2 = 0; bus.funct7_5 = 0; bus.imm = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        check("rst_pc", bus.pc, RESET_PC);
        check("rst_retire", {31'b0, bus.retire}, 32'd0);
        check("rst_trap", {31'b0, bus.trap}, 32'd0);
        check("rst_cause", {28'b0, bus.trap_cause}, 32'd0);
        check("rst_ready", {31'b0, bus.in_ready}, 32'd1);
        issue(mk(IMM, 1, 0, 0, 0, 0, 32'd5));
        issue(mk(STORE, 0, 2, 0, 1, 0, 32'h40));
        issue(mk(LOAD, 2, 2, 0, 0, 0, 32'h40));
        issue(mk(IMM, 3, 0, 0, 0, 0, 32'h80));
        issue(mk(STORE, 0, 0, 0, 3, 0, 32'h80));
        issue(mk(LOAD, 4, 0, 0, 0, 0, 32'h80));
        issue(mk(LOAD, 5, 4, 0, 0, 0, 32'h80));
        issue(mk(JAL, 0, 0, 0, 0, 0, 32'h10 - m_pc));
        issue(mk(BR, 9, 0, 0, 0, 0, 32'hFFFFFFF8));
        issue(mk(IMM, 6, 0, 0, 0, 0, 32'h101));
        issue(mk(JAL, 0, 0, 0, 0, 0, 32'h20 - m_pc));
        issue(mk(JALR, 7, 0, 6, 0, 0, 32'h0));
        drain();
        for (int r = 1; r < 32; r++) begin
            issue(mk(LUI, 5'(r), 0, 0, 0, 0, $urandom & 32'hFFFFF000));
            issue(mk(IMM, 5'(r), 3'b100, 5'(r), 0, 0, sext12(12'($urandom))));
        end
        for (int k = 0; k < 64; k++) issue(mk(STORE, 0, 2, 0, 5'(k % 31 + 1), 0, 32'(4 * k)));
        repeat (500) issue(gen());
        drain();
        do_reset();
        issue(mk(IMM, 1, 0, 0, 0, 0, 32'h77));
        drain();
        bus.opcode = STORE; bus.rd = 0; bus.funct3 = 3'd2; bus.rs1 = 0; bus.rs2 = 1;
        bus.funct7_5 = 0; bus.imm = 32'h60; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("rstmem_busy", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        do_reset();
        check("rstmem_retire", {31'b0, bus.retire}, 32'd0);
        check("rstmem_ready", {31'b0, bus.in_ready}, 32'd1);
        issue(mk(LOAD, 2, 2, 0, 0, 0, 32'h60));
        drain();
        issue(mk(IMM, 1, 0, 0, 0, 0, 32'h5A));
        drain();
        trap_case(mk(STORE, 0, 2, 0, 1, 0, 32'h42), 4'd6);
        issue(mk(LOAD, 3, 2, 0, 0, 0, 32'h40));
        drain();
        trap_case(mk(LOAD, 3, 1, 0, 0, 0, 32'h41), 4'd4);
        trap_case(mk(BR, 0, 0, 0, 0, 0, 32'h6), 4'd0);
        trap_case(mk(JAL, 1, 0, 0, 0, 0, 32'h2), 4'd0);
        issue(mk(IMM, 1, 0, 0, 0, 0, 32'h102));
        drain();
        trap_case(mk(JALR, 2, 0, 1, 0, 0, 32'h0), 4'd0);
        issue(mk(IMM, 4, 0, 0, 0, 0, 32'h33));
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
